// File: rtl/pmu_pwr_seq_pkg.sv
// Shared types and helpers for the PMU power sequencer.
// Holds the sequencer state enum and the clk_select -> base settle count table.
package pmu_pwr_seq_pkg;

  localparam int CLK_SEL_W = 3;
  localparam int BASE_W    = 7;

  // Sleep steps run PVD -> LDO -> V2I; wake steps run the reverse order.
  typedef enum logic [2:0] {
    ACTIVE  = 3'd0,
    SLP_PVD = 3'd1,
    SLP_LDO = 3'd2,
    SLP_V2I = 3'd3,
    SLEEP   = 3'd4,
    WK_V2I  = 3'd5,
    WK_LDO  = 3'd6,
    WK_PVD  = 3'd7
  } pmu_state_e;

  // Base settle count, in pclk cycles, giving a ~3us wait at each pclk divider.
  function automatic logic [BASE_W-1:0] base_cnt(input logic [CLK_SEL_W-1:0] clk_select);
    logic [BASE_W-1:0] cnt;
    case (clk_select)
      3'd0:    cnt = 7'd96;
      3'd1:    cnt = 7'd48;
      3'd2:    cnt = 7'd24;
      3'd3:    cnt = 7'd12;
      3'd4:    cnt = 7'd6;
      3'd5:    cnt = 7'd3;
      default: cnt = 7'd2;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pmu_pwr_seq_if.sv
// Request/acknowledge interface between the SCU request logic and the sequencer.
//
// Handshake: sleep_req and wake_req are levels raised by the master and held
// until ack. The sequencer samples them only while idle (ACTIVE or SLEEP,
// busy=0); a request that does not oppose the current state is ignored. ack is
// a one-cycle pulse on the first cycle back in SLEEP or ACTIVE; busy is high for
// the whole transition and asleep is high while in SLEEP. clk_select is
// sampled on entry to each sequencing step.
interface pmu_pwr_seq_if;

  logic [2:0] clk_select;
  logic       sleep_req;
  logic       wake_req;
  logic       ack;
  logic       busy;
  logic       asleep;

  modport master (
    output clk_select,
    output sleep_req,
    output wake_req,
    input  ack,
    input  busy,
    input  asleep
  );

  modport slave (
    input  clk_select,
    input  sleep_req,
    input  wake_req,
    output ack,
    output busy,
    output asleep
  );

endinterface

// File: rtl/pmu_settle_timer.sv
// Loadable settle down-counter.
// load_val is the step length minus one; done is high on the last cycle of the
// count and then drops until the next load.
module pmu_settle_timer #(
  parameter int CNT_W = 10
) (
  input  logic             pclk,
  input  logic             prst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic             armed;

  // Count down from the loaded value; disarm once the last cycle has passed.
  always_ff @(posedge pclk) begin
    if (prst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (load) begin
      cnt   <= load_val;
      armed <= 1'b1;
    end else if (armed) begin
      if (cnt == '0) begin
        armed <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign done = armed && (cnt == '0);

endmodule

// File: rtl/pmu_pwr_seq.sv
// PMU analog power-domain sequencer.
// Walks PVD, LDO1P5 and V2I power-down pins through a fixed order on
// sleep/wake requests, holding each step for base_cnt(clk_select)*MULT cycles.
// Optional feature macro: PMU_SEQ_PVD_ABORT_EN (synchronised PVD brown-out
// input forces an automatic sleep and sets the sticky pvd_evt flag).
module pmu_pwr_seq
  import pmu_pwr_seq_pkg::*;
#(
  parameter int CNT_W    = 10,
  parameter int PVD_MULT = 1,
  parameter int LDO_MULT = 1,
  parameter int V2I_MULT = 2
) (
  input  logic                pclk,
  input  logic                prst,
  pmu_pwr_seq_if.slave        req_if,
  input  logic                pvd_in,
  input  logic                pvd_clr,
  output logic                pd_pvd,
  output logic                pd_ldo15,
  output logic                pd_v2i,
  output logic                pvd_evt,
  output pmu_state_e          dbg_state
);

  pmu_state_e       state;
  pmu_state_e       state_nxt;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic [CNT_W-1:0] base_ext;
  logic [CNT_W-1:0] step_mult;
  logic [CNT_W-1:0] step_len;
  logic             pvd_trig;
  logic             ack_q;

  // ---------------------------------------------------------------------------
  // Brown-out handling
  // ---------------------------------------------------------------------------
`ifdef PMU_SEQ_PVD_ABORT_EN
  logic pvd_s1;
  logic pvd_s2;
  logic pvd_evt_q;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge pclk) begin
    if (prst) begin
      pvd_s1 <= 1'b0;
      pvd_s2 <= 1'b0;
    end else begin
      pvd_s1 <= pvd_in;
      pvd_s2 <= pvd_s1;
    end
  end

  // A brown-out only matters while fully powered; it then acts like sleep_req.
  assign pvd_trig = (state == ACTIVE) && pvd_s2;

  // Sticky brown-out flag; a new event beats a simultaneous clear.
  always_ff @(posedge pclk) begin
    if (prst) begin
      pvd_evt_q <= 1'b0;
    end else if (pvd_trig) begin
      pvd_evt_q <= 1'b1;
    end else if (pvd_clr) begin
      pvd_evt_q <= 1'b0;
    end
  end

  assign pvd_evt = pvd_evt_q;
`else
  logic unused_pvd;

  assign pvd_trig   = 1'b0;
  assign pvd_evt    = 1'b0;
  assign unused_pvd = pvd_in | pvd_clr;
`endif

  // ---------------------------------------------------------------------------
  // Step timer: length is latched from clk_select when the step is entered
  // ---------------------------------------------------------------------------
  assign base_ext = CNT_W'(base_cnt(req_if.clk_select));
  assign step_len = base_ext * step_mult;
  assign tmr_val  = step_len - CNT_W'(1);

  pmu_settle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .pclk     (pclk),
    .prst     (prst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state <= ACTIVE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; a timer load accompanies every entry into a step state.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    step_mult = '0;
    case (state)
      ACTIVE: begin
        if (req_if.sleep_req || pvd_trig) begin
          state_nxt = SLP_PVD;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(PVD_MULT);
        end
      end
      SLP_PVD: begin
        if (tmr_done) begin
          state_nxt = SLP_LDO;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(LDO_MULT);
        end
      end
      SLP_LDO: begin
        if (tmr_done) begin
          state_nxt = SLP_V2I;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(V2I_MULT);
        end
      end
      SLP_V2I: begin
        if (tmr_done) begin
          state_nxt = SLEEP;
        end
      end
      SLEEP: begin
        if (req_if.wake_req) begin
          state_nxt = WK_V2I;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(V2I_MULT);
        end
      end
      WK_V2I: begin
        if (tmr_done) begin
          state_nxt = WK_LDO;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(LDO_MULT);
        end
      end
      WK_LDO: begin
        if (tmr_done) begin
          state_nxt = WK_PVD;
          tmr_load  = 1'b1;
          step_mult = CNT_W'(PVD_MULT);
        end
      end
      WK_PVD: begin
        if (tmr_done) begin
          state_nxt = ACTIVE;
        end
      end
      default: begin
        state_nxt = ACTIVE;
      end
    endcase
  end

  // Power pins and ack update on the edge that enters a state, so each change
  // is visible on the first cycle of that state.
  always_ff @(posedge pclk) begin
    if (prst) begin
      pd_pvd   <= 1'b0;
      pd_ldo15 <= 1'b0;
      pd_v2i   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (state_nxt != state) begin
        case (state_nxt)
          SLP_PVD: pd_pvd   <= 1'b1;
          SLP_LDO: pd_ldo15 <= 1'b1;
          SLP_V2I: pd_v2i   <= 1'b1;
          SLEEP:   ack_q    <= 1'b1;
          WK_V2I:  pd_v2i   <= 1'b0;
          WK_LDO:  pd_ldo15 <= 1'b0;
          WK_PVD:  pd_pvd   <= 1'b0;
          ACTIVE:  ack_q    <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign req_if.ack    = ack_q;
  assign req_if.busy   = (state != ACTIVE) && (state != SLEEP);
  assign req_if.asleep = (state == SLEEP);
  assign dbg_state     = state;

endmodule

// File: tb/tb_pmu_pwr_seq.sv
// Self-checking bench for pmu_pwr_seq: timing-table vectors, hand-written
// corner sequences and random stimulus against a step-list reference model.
module tb_pmu_pwr_seq;
  import pmu_pwr_seq_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       pclk = 1'b0;
  logic       prst;
  logic       pvd_in;
  logic       pvd_clr;
  logic       pd_pvd;
  logic       pd_ldo15;
  logic       pd_v2i;
  logic       pvd_evt;
  pmu_state_e dbg_state;

  pmu_pwr_seq_if req_if();

  pmu_pwr_seq dut (
    .pclk      (pclk),
    .prst      (prst),
    .req_if    (req_if),
    .pvd_in    (pvd_in),
    .pvd_clr   (pvd_clr),
    .pd_pvd    (pd_pvd),
    .pd_ldo15  (pd_ldo15),
    .pd_v2i    (pd_v2i),
    .pvd_evt   (pvd_evt),
    .dbg_state (dbg_state)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  // ---------------- reference model ----------------
  // A transition is a list of three steps; each step powers one domain on or
  // off and lasts base(clk_select at entry) * domain multiplier cycles.
  int  base_tab[8] = '{96, 48, 24, 12, 6, 3, 2, 2};
  int  mult_tab[3] = '{1, 1, 2};  // 0 = PVD, 1 = LDO, 2 = V2I
  bit  m_awake;
  int  m_step;                    // -1 when idle
  bit  m_going_sleep;
  int  m_left;
  bit  m_pd[3];
  bit  m_ack;
  bit  m_evt;
  bit  m_p1;
  bit  m_p2;

  function automatic int dom_of(input bit going_sleep, input int step);
    return going_sleep ? step : 2 - step;
  endfunction

  function automatic void model_enter(input int cs);
    int dom;
    dom         = dom_of(m_going_sleep, m_step);
    m_pd[dom]   = m_going_sleep;
    m_left      = base_tab[cs] * mult_tab[dom];
  endfunction

  function automatic void model_edge(input bit rst, input int cs, input bit sr,
                                     input bit wr, input bit pin, input bit clr);
    bit trig;
    if (rst) begin
      m_awake = 1'b1; m_step = -1; m_left = 0; m_ack = 1'b0; m_evt = 1'b0;
      m_p1 = 1'b0; m_p2 = 1'b0;
      for (int i = 0; i < 3; i++) m_pd[i] = 1'b0;
      return;
    end
    trig  = 1'b0;
`ifdef PMU_SEQ_PVD_ABORT_EN
    trig  = m_awake && (m_step < 0) && m_p2;
`endif
    m_ack = 1'b0;
    if (m_step >= 0) begin
      m_left--;
      if (m_left == 0) begin
        if (m_step < 2) begin
          m_step++;
          model_enter(cs);
        end else begin
          m_step  = -1;
          m_awake = !m_going_sleep;
          m_ack   = 1'b1;
        end
      end
    end else if (m_awake && (sr || trig)) begin
      m_going_sleep = 1'b1; m_step = 0; model_enter(cs);
    end else if (!m_awake && wr) begin
      m_going_sleep = 1'b0; m_step = 0; model_enter(cs);
    end
`ifdef PMU_SEQ_PVD_ABORT_EN
    if (trig) m_evt = 1'b1;
    else if (clr) m_evt = 1'b0;
    m_p2 = m_p1;
    m_p1 = pin;
`endif
  endfunction

  function automatic logic [6:0] model_out();
    return {m_ack, m_step >= 0, !m_awake && (m_step < 0), m_pd[0], m_pd[1], m_pd[2], m_evt};
  endfunction

  function automatic logic [6:0] dut_out();
    return {req_if.ack, req_if.busy, req_if.asleep, pd_pvd, pd_ldo15, pd_v2i, pvd_evt};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: model follows the inputs the DUT samples, outputs compared on the falling edge.
  task automatic tick();
    logic [6:0] exp;
    @(posedge pclk);
    model_edge(prst, int'(req_if.clk_select), req_if.sleep_req, req_if.wake_req, pvd_in, pvd_clr);
    exp_q.push_back(model_out());
    @(negedge pclk);
    exp = exp_q.pop_front();
    check("model", 32'(dut_out()), 32'(exp));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req_if.sleep_req = 1'b0;
    req_if.wake_req  = 1'b0;
    pvd_in           = 1'b0;
    pvd_clr          = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    prst = 1'b1;
    tick();
    tick();
    prst = 1'b0;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return req_if.asleep;
      1:       return pd_ldo15;
      default: return pd_v2i;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit);
    int n = 0;
    while (!sig(which) && n < limit) begin
      tick();
      n++;
    end
    check($sformatf("wait_sig%0d", which), 32'(sig(which)), 32'd1);
  endtask

  // ---------------- timing table ----------------
  // outputs packed as {ack, busy, asleep, pd_pvd, pd_ldo15, pd_v2i, pvd_evt}
  typedef struct {
    bit         from_sleep;
    logic [2:0] cs;
    int         cyc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int c;
    req_if.clk_select = 3'd7;
    idle_inputs();
    prst = 1'b1;

    vecs[0]  = '{1'b0, 3'd3, 1,  7'b0101000};
    vecs[1]  = '{1'b0, 3'd3, 12, 7'b0101000};
    vecs[2]  = '{1'b0, 3'd3, 13, 7'b0101100};
    vecs[3]  = '{1'b0, 3'd3, 24, 7'b0101100};
    vecs[4]  = '{1'b0, 3'd3, 25, 7'b0101110};
    vecs[5]  = '{1'b0, 3'd3, 48, 7'b0101110};
    vecs[6]  = '{1'b0, 3'd3, 49, 7'b1011110};
    vecs[7]  = '{1'b1, 3'd5, 1,  7'b0101100};
    vecs[8]  = '{1'b1, 3'd5, 6,  7'b0101100};
    vecs[9]  = '{1'b1, 3'd5, 7,  7'b0101000};
    vecs[10] = '{1'b1, 3'd5, 10, 7'b0100000};
    vecs[11] = '{1'b1, 3'd5, 12, 7'b0100000};
    vecs[12] = '{1'b1, 3'd5, 13, 7'b1000000};

    do_reset();
    check("reset_state", 32'(dut_out()), 32'd0);

    // Table: request raised in cycle T, outputs checked cyc cycles later.
    for (int i = 0; i < 13; i++) begin
      do_reset();
      if (vecs[i].from_sleep) begin
        req_if.clk_select = 3'd7;
        req_if.sleep_req  = 1'b1;
        wait_for(0, 60);
        req_if.sleep_req  = 1'b0;
        tick();
      end
      req_if.clk_select = vecs[i].cs;
      if (vecs[i].from_sleep) req_if.wake_req = 1'b1;
      else                    req_if.sleep_req = 1'b1;
      repeat (vecs[i].cyc) tick();
      check($sformatf("vec%0d", i), 32'(dut_out()), 32'(vecs[i].exp));
      idle_inputs();
    end

    // clk_select changed mid-step only affects later steps.
    do_reset();
    req_if.clk_select = 3'd0;
    req_if.sleep_req  = 1'b1;
    wait_for(1, 200);
    req_if.clk_select = 3'd7;
    c = 0;
    while (!pd_v2i && c < 300) begin tick(); c++; end
    check("slp_ldo_len", 32'(c), 32'd96);
    c = 0;
    while (!req_if.asleep && c < 300) begin tick(); c++; end
    check("slp_v2i_len", 32'(c), 32'd4);
    idle_inputs();

    // Both requests in ACTIVE start sleep; a wake pulse while busy is ignored.
    do_reset();
    req_if.clk_select = 3'd6;
    req_if.sleep_req  = 1'b1;
    req_if.wake_req   = 1'b1;
    tick();
    check("both_req", 32'({req_if.busy, req_if.asleep, pd_pvd}), 32'b101);
    req_if.sleep_req = 1'b0;
    tick();
    req_if.wake_req  = 1'b0;
    wait_for(0, 60);
    repeat (3) tick();
    check("wake_pulse_ignored", 32'({req_if.asleep, req_if.busy}), 32'b10);

    // Reset in the middle of SLP_V2I.
    do_reset();
    req_if.clk_select = 3'd7;
    req_if.sleep_req  = 1'b1;
    wait_for(2, 60);
    tick();
    prst = 1'b1;
    tick();
    prst = 1'b0;
    req_if.sleep_req = 1'b0;
    check("reset_mid_seq", 32'(dut_out()), 32'd0);

    // Brown-out input.
    do_reset();
    req_if.clk_select = 3'd7;
`ifdef PMU_SEQ_PVD_ABORT_EN
    pvd_in = 1'b1;
    tick();
    tick();
    check("pvd_t2", 32'({pvd_evt, pd_pvd}), 32'b00);
    tick();
    check("pvd_t3", 32'({pvd_evt, pd_pvd}), 32'b11);
    pvd_in  = 1'b0;
    pvd_clr = 1'b1;
    tick();
    pvd_clr = 1'b0;
    check("pvd_clr", 32'(pvd_evt), 32'd0);
    wait_for(0, 60);
`else
    pvd_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pvd_clr = 1'(i & 1);
      tick();
    end
    check("pvd_unused", 32'({pvd_evt, req_if.busy, pd_pvd}), 32'b000);
`endif
    idle_inputs();

    // Random stimulus against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      prst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 9) == 0) req_if.clk_select = 3'($urandom_range(2, 7));
      if ($urandom_range(0, 15) == 0) req_if.sleep_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) req_if.wake_req  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) pvd_in = ~pvd_in;
      pvd_clr = ($urandom_range(0, 11) == 0);
      tick();
    end
    prst = 1'b0;
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
